// File: rtl/usb_serial_stream_gen_pkg.sv
// Shared types and helpers for the usb_serial stream generator.
// Holds the mode/state enums and the ASCII case-swap used by echo mode 11.
package usb_serial_gen_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE      = 2'b00,
    MODE_PATTERN   = 2'b01,
    MODE_ECHO      = 2'b10,
    MODE_ECHO_SWAP = 2'b11
  } mode_t;

  typedef enum logic {
    WAIT  = 1'b0,
    BURST = 1'b1
  } gen_state_t;

  // Letters flip case; every other byte passes through unchanged.
  function automatic logic [7:0] swap_case(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
    if (b >= 8'h41 && b <= 8'h5a) return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/usb_serial_stream_gen_if.sv
// Byte-stream bundle between the generator and the usb_serial core.
// A byte moves on a rising edge where tvalid && tready; a raised tvalid keeps
// tvalid and tdata unchanged until that transfer happens, and tvalid never
// depends on tready.
interface usb_serial_stream_gen_if;
  logic       rx_tvalid;
  logic       rx_tready;
  logic [7:0] rx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;

  modport master (
    input  rx_tvalid, rx_tdata, tx_tready,
    output rx_tready, tx_tvalid, tx_tdata
  );

  modport slave (
    output rx_tvalid, rx_tdata, tx_tready,
    input  rx_tready, tx_tvalid, tx_tdata
  );
endinterface

// File: rtl/usb_serial_stream_gen_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally.
// Pointers carry one extra bit so full and empty are distinguishable.
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk48mhz,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk48mhz) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usb_serial_stream_gen.sv
// Pattern/echo traffic source and rx sink for the usb_serial core, with a
// free-running burst scheduler, an echo FIFO and rx statistics for the LEDs.
module usb_serial_stream_gen
  import usb_serial_gen_pkg::*;
#(
  parameter int unsigned PERIOD     = 134217728,
  parameter int unsigned BURST_LEN  = 8,
  parameter logic [7:0]  CHAR_BASE  = 8'h30,
  parameter int unsigned CHAR_SPAN  = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk48mhz,
  input  logic                          rstn,
  input  logic [1:0]                    mode,
  usb_serial_stream_gen_if.master       bus,
  output logic [7:0]                    last_rx,
  output logic [15:0]                   rx_count,
  output gen_state_t                    dbg_state
);
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CNT_W-1:0] period_cnt;
  gen_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       off_q, off_d;
  mode_t            eff_mode;

  logic       echo_on;
  logic       burst_active;
  logic       tx_hs;
  logic       rx_hs;
  logic       mode_load;
  logic       fifo_flush;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign echo_on      = (eff_mode == MODE_ECHO) || (eff_mode == MODE_ECHO_SWAP);
  assign burst_active = (state_q == BURST);
  assign tx_hs        = bus.tx_tvalid && bus.tx_tready;
  assign rx_hs        = bus.rx_tvalid && bus.rx_tready;
  // The mode only changes between bursts and with no byte left on the tx port.
  assign mode_load    = !burst_active && (!bus.tx_tvalid || tx_hs);
  assign fifo_flush   = mode_load && echo_on && !mode[1];
  assign fifo_push    = rx_hs && echo_on;
  assign fifo_pop     = tx_hs && !burst_active && echo_on;
  assign dbg_state    = state_q;

  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      period_cnt <= '0;
    end else if (period_cnt == CNT_W'(PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      eff_mode <= MODE_IDLE;
    end else if (mode_load) begin
      eff_mode <= mode_t'(mode);
    end
  end

  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT;
      idx_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
    end
  end

  // A counter wrap seen while still in BURST is simply missed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    case (state_q)
      WAIT: begin
        if (eff_mode == MODE_PATTERN && period_cnt == '0) begin
          state_d = BURST;
          idx_d   = '0;
          off_d   = '0;
        end
      end
      BURST: begin
        if (tx_hs) begin
          if (idx_q == IDX_W'(BURST_LEN - 1)) state_d = WAIT;
          else                                idx_d   = idx_q + IDX_W'(1);
          off_d = (off_q == 8'(CHAR_SPAN - 1)) ? 8'h00 : off_q + 8'h01;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    bus.tx_tvalid = 1'b0;
    bus.tx_tdata  = 8'h00;
    if (burst_active) begin
      bus.tx_tvalid = 1'b1;
      bus.tx_tdata  = CHAR_BASE + off_q;
    end else if (echo_on && !fifo_empty) begin
      bus.tx_tvalid = 1'b1;
      bus.tx_tdata  = (eff_mode == MODE_ECHO_SWAP) ? swap_case(fifo_head) : fifo_head;
    end
  end

  assign bus.rx_tready = echo_on ? !fifo_full : 1'b1;

  stream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk48mhz (clk48mhz),
    .rstn     (rstn),
    .push     (fifo_push),
    .din      (bus.rx_tdata),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      last_rx  <= 8'h00;
      rx_count <= 16'h0000;
    end else if (rx_hs) begin
      last_rx  <= bus.rx_tdata;
      rx_count <= rx_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_usb_serial_stream_gen.sv
// Directed bench for usb_serial_stream_gen: expected tx bytes (with optional
// display cycle) are queued by the stimulus and consumed by a tx monitor.
module tb_usb_serial_stream_gen;
  import usb_serial_gen_pkg::*;

  localparam int W = 24;  // {display cycle or 16'hFFFF, byte}

  logic       clk48mhz = 1'b0;
  logic       rstn     = 1'b0;
  logic [1:0] mode     = 2'b01;
  logic [7:0] last_rx;
  logic [15:0] rx_count;
  gen_state_t dbg_state;

  usb_serial_stream_gen_if bus ();

  usb_serial_stream_gen #(
    .PERIOD     (64),
    .BURST_LEN  (12),
    .CHAR_BASE  (8'h30),
    .CHAR_SPAN  (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk48mhz  (clk48mhz),
    .rstn      (rstn),
    .mode      (mode),
    .bus       (bus.master),
    .last_rx   (last_rx),
    .rx_count  (rx_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk48mhz = ~clk48mhz;

  int unsigned cyc;
  always @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int unsigned c, input logic [7:0] b);
    exp_q.push_back({c[15:0], b});
  endtask

  function automatic logic [7:0] pat_char(input int k);
    return 8'h30 + 8'(k % 10);
  endfunction

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk48mhz) begin
    logic [W-1:0] e;
    #2;
    if (rstn) begin
      if (prev_stall) begin
        checks++;
        if (!(bus.tx_tvalid && bus.tx_tdata == prev_data)) begin
          errors++;
          $display("FAIL tx_hold got v=%0b d=%0h want v=1 d=%0h (cycle %0d)",
                   bus.tx_tvalid, bus.tx_tdata, prev_data, cyc);
        end
      end
      if (bus.tx_tvalid && bus.tx_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %0h want nothing (cycle %0d)", bus.tx_tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e[7:0] != bus.tx_tdata || (e[23:8] != 16'hFFFF && e[23:8] != cyc[15:0])) begin
            errors++;
            $display("FAIL tx_byte got %0h@%0d want %0h@%0d",
                     bus.tx_tdata, cyc, e[7:0], e[23:8]);
          end
        end
      end
      prev_stall = bus.tx_tvalid && !bus.tx_tready;
      prev_data  = bus.tx_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int unsigned target);
    do @(negedge clk48mhz); while (cyc < target);
  endtask

  task automatic sample_point();
    @(negedge clk48mhz);
    #3;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic rdy;
    bit   done = 1'b0;
    @(negedge clk48mhz);
    bus.rx_tvalid = 1'b1;
    bus.rx_tdata  = b;
    for (int i = 0; i < 100 && !done; i++) begin
      #2 rdy = bus.rx_tready;
      @(negedge clk48mhz);
      done = rdy;
    end
    bus.rx_tvalid = 1'b0;
    if (!done) chk("rx_accept_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned nxt;
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata  = 8'h00;
    bus.tx_tready = 1'b1;

    repeat (3) @(negedge clk48mhz);
    #3;
    chk("rst_tx_tvalid", 32'(bus.tx_tvalid), 32'(0));
    chk("rst_tx_tdata",  32'(bus.tx_tdata),  32'(0));
    chk("rst_last_rx",   32'(last_rx),       32'(0));
    chk("rst_rx_count",  32'(rx_count),      32'(0));
    chk("rst_rx_tready", 32'(bus.rx_tready), 32'(1));
    chk("rst_state",     32'(dbg_state),     32'(WAIT));

    // Pattern: first start after a full period, 12 back-to-back bytes.
    @(negedge clk48mhz);
    rstn = 1'b1;
    for (int k = 0; k < 12; k++) push_exp(65 + k, pat_char(k));
    wait_cyc(100);
    #3 chk("pattern_idle_gap", 32'(bus.tx_tvalid), 32'(0));

    // Backpressure: toggle then stall across the next wrap so it is skipped.
    push_exp(129, pat_char(0));
    for (int k = 1; k < 12; k++) push_exp(32'hFFFF, pat_char(k));
    wait_cyc(129);
    bus.tx_tready = 1'b1;
    for (int c = 130; c <= 140; c++) begin
      @(negedge clk48mhz);
      bus.tx_tready = (c % 2 == 1);
    end
    @(negedge clk48mhz);
    bus.tx_tready = 1'b0;
    wait_cyc(201);
    bus.tx_tready = 1'b1;
    for (int k = 0; k < 12; k++) push_exp(257 + k, pat_char(k));

    // Request echo mid-burst; an rx byte during the burst is counted, not echoed.
    wait_cyc(260);
    mode = 2'b10;
    send_rx(8'h70);
    wait_cyc(280);
    bus.tx_tready = 1'b0;
    send_rx(8'h68); push_exp(32'hFFFF, 8'h68);
    send_rx(8'h69); push_exp(32'hFFFF, 8'h69);
    send_rx(8'h6a); push_exp(32'hFFFF, 8'h6a);
    send_rx(8'h6b); push_exp(32'hFFFF, 8'h6b);
    sample_point();
    chk("echo_full_rx_tready", 32'(bus.rx_tready), 32'(0));
    chk("echo_head_valid",     32'(bus.tx_tvalid), 32'(1));
    chk("echo_head_data",      32'(bus.tx_tdata),  32'h68);
    push_exp(32'hFFFF, 8'h6c);
    fork
      send_rx(8'h6c);
      begin
        repeat (3) @(negedge clk48mhz);
        bus.tx_tready = 1'b1;
      end
    join
    repeat (10) @(negedge clk48mhz);
    #3;
    chk("echo_rx_count", 32'(rx_count), 32'(6));
    chk("echo_last_rx",  32'(last_rx),  32'h6c);

    // Case-swap echo.
    mode = 2'b11;
    repeat (2) @(negedge clk48mhz);
    send_rx(8'h61); push_exp(32'hFFFF, 8'h41);
    send_rx(8'h5a); push_exp(32'hFFFF, 8'h7a);
    send_rx(8'h35); push_exp(32'hFFFF, 8'h35);
    repeat (5) @(negedge clk48mhz);
    #3;
    chk("swap_last_rx",  32'(last_rx),  32'h35);
    chk("swap_rx_count", 32'(rx_count), 32'(9));

    // Leave echo with bytes queued: change waits for one transfer, then flushes.
    bus.tx_tready = 1'b0;
    send_rx(8'h78); push_exp(32'hFFFF, 8'h58);
    send_rx(8'h79);
    send_rx(8'h7a);
    mode = 2'b00;
    repeat (5) @(negedge clk48mhz);
    #3;
    chk("leave_wait_valid", 32'(bus.tx_tvalid), 32'(1));
    chk("leave_wait_data",  32'(bus.tx_tdata),  32'h58);
    @(negedge clk48mhz);
    bus.tx_tready = 1'b1;
    @(negedge clk48mhz);
    #3;
    chk("leave_flushed_valid", 32'(bus.tx_tvalid), 32'(0));
    chk("leave_idle_rx_tready", 32'(bus.rx_tready), 32'(1));
    repeat (3) @(negedge clk48mhz);
    #3;
    chk("leave_rx_count", 32'(rx_count), 32'(12));

    // Reset in the middle of a burst.
    mode = 2'b01;
    @(negedge clk48mhz);
    nxt = ((cyc + 2) / 64 + 1) * 64 + 1;
    for (int k = 0; k < 3; k++) push_exp(nxt + k, pat_char(k));
    wait_cyc(nxt + 3);
    #1 rstn = 1'b0;
    #2;
    chk("midrst_tx_tvalid", 32'(bus.tx_tvalid), 32'(0));
    chk("midrst_tx_tdata",  32'(bus.tx_tdata),  32'(0));
    chk("midrst_last_rx",   32'(last_rx),       32'(0));
    chk("midrst_rx_count",  32'(rx_count),      32'(0));
    chk("midrst_rx_tready", 32'(bus.rx_tready), 32'(1));
    chk("midrst_state",     32'(dbg_state),     32'(WAIT));
    repeat (3) @(negedge clk48mhz);
    rstn = 1'b1;
    for (int k = 0; k < 12; k++) push_exp(65 + k, pat_char(k));
    wait_cyc(90);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_serial_stream_gen.md
# usb_serial_stream_gen

Parametrised stream source/sink sitting between the `usb_serial` core's rx/tx AXI-stream ports and board-level logic. It generalises the fixed "8 ASCII digits every 2^27 cycles" demo traffic in four ways: burst length, period and character range are configurable, echo and case-swap loopback modes are added, and rx statistics are exposed.

## Interface
- `PERIOD`, 134217728: cycles between scheduled burst starts; ≥ 2.
- `BURST_LEN`, 8: bytes per pattern burst; 1..256.
- `CHAR_BASE`, 8'h30: first pattern character.
- `CHAR_SPAN`, 10: number of pattern characters before wrap; 1..256, CHAR_BASE+CHAR_SPAN ≤ 256.
- `FIFO_DEPTH`, 16: echo buffer depth, power of 2, ≥ 2.

Ports:
- `clk48mhz`  in  1  sole clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `mode`  in  2  requested mode: 00 idle, 01 pattern, 10 echo, 11 echo with case swap.
- `rx_tvalid`  in  1  rx byte valid from `usb_serial`.
- `rx_tready`  out  1  rx accept.
- `rx_tdata`  in  8  rx byte.
- `tx_tvalid`  out  1  tx byte valid to `usb_serial`.
- `tx_tready`  in  1  tx accept.
- `tx_tdata`  out  8  tx byte.
- `last_rx`  out  8  last accepted rx byte (LED display).
- `rx_count`  out  16  accepted rx bytes, wraps.

## Operation
- Handshake: transfer when `tvalid && tready` on a rising edge. Once `tx_tvalid` is high, `tx_tvalid` and `tx_tdata` hold until accepted.
- Effective mode `eff_mode`, reset 00, loads from `mode` only when no burst is active and no tx byte is pending (`!tx_tvalid` or a handshake occurs this cycle). An in-flight burst always completes.
- Period counter: free-running 0..PERIOD-1 in every mode, wraps to 0.
- Pattern FSM, active in mode 01 only: WAIT → BURST when the counter is 0; BURST → WAIT on the handshake of byte BURST_LEN-1.
  - The byte index and character offset clear at each burst start.
  - Byte k = CHAR_BASE + (k mod CHAR_SPAN).
  - If a wrap occurs during BURST (backpressure), that start is skipped. The next burst starts at the next counter 0.
- Echo (10/11): accepted rx bytes are pushed into a FIFO. `tx_tvalid` = !empty, and `tx_tdata` = FIFO head.
  - Mode 11 swaps 'a'–'z' and 'A'–'Z' on output. All other bytes pass unchanged.
- `rx_tready`: in modes 00/01 it is 1. In modes 10/11 it is `!full`; a full FIFO deasserts it even when a pop occurs the same cycle.
- Leaving echo mode (`eff_mode` update from 1x to 0x) flushes the FIFO.
- `last_rx` and `rx_count` update on every rx handshake in all modes.

## Timing
- Reset values: `tx_tvalid`=0, `tx_tdata`=0, `last_rx`=0, `rx_count`=0, FSM=WAIT, period counter=0, FIFO empty, `eff_mode`=00, so `rx_tready`=1.
- Reset is asynchronous in all cases. Asserting it mid-burst or mid-echo drops all pending data immediately.
- Pattern latency: period counter reads 0 at edge N → `tx_tvalid`=1 with byte 0 after edge N+1.
  - With `tx_tready` held at 1, one byte is sent per cycle. A burst occupies BURST_LEN consecutive cycles.
- Echo latency: rx handshake at edge N → byte appears on `tx_tvalid`/`tx_tdata` after edge N. It is accepted at edge N+1 at the earliest.
- Echo throughput: one byte per cycle sustained; simultaneous push and pop are allowed when the FIFO is not full.
- `last_rx` and `rx_count` become visible one cycle after the handshake edge.
- Mode change latency: one cycle after the eligibility condition holds.

## Structure
- Package `usb_serial_gen_pkg`: `mode_t` enum (MODE_IDLE, MODE_PATTERN, MODE_ECHO, MODE_ECHO_SWAP), `gen_state_t` enum (WAIT, BURST), and the case-swap function.
- Sub-module `stream_fifo`: synchronous FIFO parametrised by width and depth, with push, pop, flush, full and empty. Head data is combinational.
- Top-level logic: period counter, pattern FSM, mode register, tx mux and rx statistics.

## Test plan
- Pattern with PERIOD=64, BURST_LEN=12, CHAR_SPAN=10, `tx_tready`=1 → bytes '0'..'9','0','1' on 12 consecutive cycles starting 1 cycle after counter 0, then silence until the next counter 0.
- Pattern with `tx_tready` toggling 1/0, BURST_LEN=40 > PERIOD/2 → `tx_tdata` stable while stalled, no byte lost or duplicated, missed start skipped, next burst again starts at '0'.
- Echo with FIFO_DEPTH=4, `tx_tready`=0, offer 5 bytes → `rx_tready`=0 after 4 accepted. Release `tx_tready` → 4 bytes out in order, then 5th accepted and echoed; `rx_count`=5.
- Mode 11, send 'a','Z','5' → tx 'A','z','5'; `last_rx`='5'.
- Switch `mode` 01→10 in mid-burst → burst completes fully before echo begins. Switch 10→00 with 3 bytes queued and `tx_tready`=0 → change waits for a handshake, then FIFO flushed and `tx_tvalid`=0.
- Assert `rstn`=0 mid-burst → all outputs return to reset values immediately. After release, the first burst waits for a full PERIOD.
